// File: rtl/pq_pkg.sv
// Shared definitions for the max priority queue and its clients:
// op encodings on the queue interface and the batch-sort client state.
package pq_pkg;

    localparam logic [1:0] PQ_OP_NOP  = 2'b00;
    localparam logic [1:0] PQ_OP_PUSH = 2'b01;
    localparam logic [1:0] PQ_OP_POP  = 2'b10;
    localparam logic [1:0] PQ_OP_TOP  = 2'b11;

    typedef enum logic [0:0] {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } pq_state_t;

endpackage

// File: rtl/pq_sort_out_reg.sv
// One-entry registered output stage with valid/ready semantics.
// A load takes priority over a consume, so back-to-back beats need no bubble.
module pq_sort_out_reg #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    input  logic                  consume,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  out_last
);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees pre-edge values regardless of process ordering.
    // NOTE: the data register is reset too, so no stale value from an
    // interrupted batch is ever visible on the output after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_data  <= load_data;
            out_valid <= 1'b1;
            out_last  <= load_last;
        end else if (consume) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: rtl/pq_batch_sort_initiator.sv
// Batch sorter built on an external max priority queue: PUSHes a batch in,
// then POPs it out in descending order with m_last on the final value.
module pq_batch_sort_initiator
    import pq_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PQ_DEPTH   = 8,
    parameter int CNT_WIDTH  = $clog2(PQ_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic [1:0]            pq_op,
    output logic [DATA_WIDTH-1:0] pq_data,
    output logic                  pq_push_valid,
    input  logic                  pq_full_n,
    input  logic [DATA_WIDTH-1:0] pq_max,
    input  logic                  pq_max_valid,
    output logic                  pq_pop_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  err_underflow
);

    pq_state_t            state_q, state_d;
    logic [CNT_WIDTH-1:0] count_q;
    logic                 count_zero;
    logic                 out_free;
    logic                 push_acc;
    logic                 pop_en;
    logic                 underflow;
    logic                 batch_full;

    assign count_zero = (count_q == '0);
    assign out_free   = !m_valid || m_ready;
    assign push_acc   = (state_q == FILL) && s_valid && s_ready;
    assign batch_full = (count_q == CNT_WIDTH'(PQ_DEPTH - 1));
    assign pop_en     = (state_q == DRAIN) && !count_zero && out_free && pq_max_valid;
    // The queue ran dry while values were still owed: abandon the batch.
    assign underflow  = (state_q == DRAIN) && !count_zero && !pq_max_valid;
    assign pq_data    = s_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL: begin
                if (push_acc && (s_last || batch_full)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (count_zero && out_free) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        s_ready       = 1'b0;
        pq_op         = PQ_OP_NOP;
        pq_push_valid = 1'b0;
        pq_pop_ready  = 1'b0;
        if (!reset) begin
            case (state_q)
                FILL: begin
                    s_ready       = pq_full_n;
                    pq_push_valid = s_valid;
                    pq_op         = s_valid ? PQ_OP_PUSH : PQ_OP_NOP;
                end
                DRAIN: begin
                    pq_op        = PQ_OP_POP;
                    pq_pop_ready = pop_en;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (push_acc) begin
            count_q <= count_q + CNT_WIDTH'(1);
        end else if (underflow) begin
            count_q <= '0;
        end else if (pop_en) begin
            count_q <= count_q - CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_underflow <= 1'b0;
        end else if (underflow) begin
            err_underflow <= 1'b1;
        end
    end

    pq_sort_out_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out (
        .clk       (clk),
        .reset     (reset),
        .load      (pop_en),
        .load_data (pq_max),
        .load_last (count_q == CNT_WIDTH'(1)),
        .consume   (m_valid && m_ready),
        .out_data  (m_data),
        .out_valid (m_valid),
        .out_last  (m_last)
    );

endmodule

// File: tb/tb_pq_batch_sort_initiator.sv
// Directed bench for pq_batch_sort_initiator with a behavioural max
// priority queue attached on the queue side.
module tb_pq_batch_sort_initiator;
    import pq_pkg::*;

    localparam int DW = 8;
    localparam int DEPTH = 8;

    logic          clk;
    logic          reset;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_last;
    logic          s_ready;
    logic [1:0]    pq_op;
    logic [DW-1:0] pq_data;
    logic          pq_push_valid;
    logic          pq_full_n;
    logic [DW-1:0] pq_max;
    logic          pq_max_valid;
    logic          pq_pop_ready;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_last;
    logic          m_ready;
    logic          err_underflow;

    int n_cmp = 0;
    int n_mis = 0;

    pq_batch_sort_initiator #(
        .DATA_WIDTH (DW),
        .PQ_DEPTH   (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_last        (s_last),
        .s_ready       (s_ready),
        .pq_op         (pq_op),
        .pq_data       (pq_data),
        .pq_push_valid (pq_push_valid),
        .pq_full_n     (pq_full_n),
        .pq_max        (pq_max),
        .pq_max_valid  (pq_max_valid),
        .pq_pop_ready  (pq_pop_ready),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_last        (m_last),
        .m_ready       (m_ready),
        .err_underflow (err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural max priority queue; force_empty makes it report empty and drop its contents.
    logic [DW-1:0] qm [DEPTH];
    int            qn = 0;
    int            imax;
    logic          force_empty;

    always_comb begin
        pq_max = '0;
        imax   = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i < qn && qm[i] >= pq_max) begin
                pq_max = qm[i];
                imax   = i;
            end
        end
    end

    assign pq_max_valid = (qn != 0) && !force_empty;
    assign pq_full_n    = (qn < DEPTH);

    always @(posedge clk) begin
        if (reset || force_empty) begin
            qn <= 0;
        end else if (pq_op == PQ_OP_PUSH && pq_push_valid && pq_full_n) begin
            qm[qn] <= pq_data;
            qn     <= qn + 1;
        end else if (pq_op == PQ_OP_POP && pq_pop_ready && pq_max_valid) begin
            qm[imax] <= qm[qn-1];
            qn       <= qn - 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] d, input logic l);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        @(negedge clk);
    endtask

    task automatic end_push();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic expect_beat(input string tag, input logic [DW-1:0] d, input logic l);
        @(negedge clk);
        check({tag, "_valid"}, 32'(m_valid), 32'd1);
        check({tag, "_data"},  32'(m_data),  32'(d));
        check({tag, "_last"},  32'(m_last),  32'(l));
    endtask

    initial begin
        reset       = 1'b1;
        s_valid     = 1'b1;
        s_data      = 8'h77;
        s_last      = 1'b0;
        m_ready     = 1'b1;
        force_empty = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // During reset nothing may be offered to the queue or the producer.
        check("rst_s_ready",    32'(s_ready),       32'd0);
        check("rst_pq_op",      32'(pq_op),         32'(PQ_OP_NOP));
        check("rst_push_valid", 32'(pq_push_valid), 32'd0);
        check("rst_pop_ready",  32'(pq_pop_ready),  32'd0);
        check("rst_m_valid",    32'(m_valid),       32'd0);
        check("rst_m_last",     32'(m_last),        32'd0);
        check("rst_m_data",     32'(m_data),        32'd0);
        check("rst_err",        32'(err_underflow), 32'd0);
        reset   = 1'b0;
        s_valid = 1'b0;
        #1;
        check("fill_s_ready", 32'(s_ready), 32'd1);
        check("fill_nop",     32'(pq_op),   32'(PQ_OP_NOP));
        @(negedge clk);

        // Batch 5,9,3,7 -> 9,7,5,3.
        push(8'd5, 1'b0);
        push(8'd9, 1'b0);
        push(8'd3, 1'b0);
        push(8'd7, 1'b1);
        end_push();
        #1;
        check("t1_drain_s_ready", 32'(s_ready), 32'd0);
        check("t1_drain_op",      32'(pq_op),   32'(PQ_OP_POP));
        check("t1_no_out_yet",    32'(m_valid), 32'd0);
        expect_beat("t1_b0", 8'd9, 1'b0);
        expect_beat("t1_b1", 8'd7, 1'b0);
        expect_beat("t1_b2", 8'd5, 1'b0);
        expect_beat("t1_b3", 8'd3, 1'b1);
        @(negedge clk);
        check("t1_idle_valid", 32'(m_valid),       32'd0);
        check("t1_fill_ready", 32'(s_ready),       32'd1);
        check("t1_err",        32'(err_underflow), 32'd0);

        // Eight values without s_last: batch closes on the eighth push.
        for (int i = 1; i <= DEPTH; i++) push(DW'(i), 1'b0);
        end_push();
        check("t2_drain_s_ready", 32'(s_ready), 32'd0);
        for (int k = DEPTH; k >= 1; k--) begin
            expect_beat($sformatf("t2_b%0d", k), DW'(k), k == 1);
            check($sformatf("t2_s_ready_%0d", k), 32'(s_ready), 32'd0);
        end
        @(negedge clk);
        check("t2_fill_ready", 32'(s_ready), 32'd1);
        check("t2_idle_valid", 32'(m_valid), 32'd0);

        // Batch 4,4,2 with m_ready 1,0,0,1,1 across the output edges.
        push(8'd4, 1'b0);
        push(8'd4, 1'b0);
        push(8'd2, 1'b1);
        end_push();
        m_ready = 1'b1;
        expect_beat("t3_b0", 8'd4, 1'b0);
        m_ready = 1'b0;
        #1;
        check("t3_stall_pop_ready0", 32'(pq_pop_ready), 32'd0);
        expect_beat("t3_hold0", 8'd4, 1'b0);
        check("t3_q_left0", 32'(qn), 32'd2);
        expect_beat("t3_hold1", 8'd4, 1'b0);
        check("t3_q_left1", 32'(qn), 32'd2);
        m_ready = 1'b1;
        expect_beat("t3_b1", 8'd4, 1'b0);
        expect_beat("t3_b2", 8'd2, 1'b1);
        @(negedge clk);
        check("t3_idle_valid", 32'(m_valid), 32'd0);

        // Single-item batch.
        push(8'hAB, 1'b1);
        end_push();
        expect_beat("t4_b0", 8'hAB, 1'b1);
        @(negedge clk);
        check("t4_fill_ready", 32'(s_ready), 32'd1);
        check("t4_idle_valid", 32'(m_valid), 32'd0);

        // Queue empties after two of four pops.
        push(8'd10, 1'b0);
        push(8'd20, 1'b0);
        push(8'd30, 1'b0);
        push(8'd40, 1'b1);
        end_push();
        expect_beat("t5_b0", 8'd40, 1'b0);
        expect_beat("t5_b1", 8'd30, 1'b0);
        force_empty = 1'b1;
        @(negedge clk);
        force_empty = 1'b0;
        check("t5_err_set",     32'(err_underflow), 32'd1);
        check("t5_abandon_val", 32'(m_valid),       32'd0);
        check("t5_still_drain", 32'(s_ready),       32'd0);
        @(negedge clk);
        check("t5_fill_ready", 32'(s_ready), 32'd1);
        check("t5_no_last",    32'(m_last),  32'd0);
        push(8'h55, 1'b1);
        end_push();
        expect_beat("t5_next", 8'h55, 1'b1);
        check("t5_err_sticky", 32'(err_underflow), 32'd1);
        @(negedge clk);

        // Reset while three values are still owed.
        push(8'd6, 1'b0);
        push(8'd5, 1'b0);
        push(8'd4, 1'b0);
        push(8'd3, 1'b1);
        end_push();
        expect_beat("t6_b0", 8'd6, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("t6_m_valid",    32'(m_valid),       32'd0);
        check("t6_m_data",     32'(m_data),        32'd0);
        check("t6_pq_op",      32'(pq_op),         32'(PQ_OP_NOP));
        check("t6_pop_ready",  32'(pq_pop_ready),  32'd0);
        check("t6_fill_ready", 32'(s_ready),       32'd1);
        check("t6_err_clear",  32'(err_underflow), 32'd0);
        @(negedge clk);
        check("t6_no_partial", 32'(m_valid), 32'd0);
        push(8'd1, 1'b0);
        push(8'd2, 1'b1);
        end_push();
        expect_beat("t6_r0", 8'd2, 1'b0);
        expect_beat("t6_r1", 8'd1, 1'b1);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
